// File: rtl/scan_doubler.sv
// Line-doubling scan converter: buffers each native-rate active line and replays it twice at double rate.
// Latency: a line starts replaying CLK_PER_PIX/2+1 clk after its end; the pixel, de and hsync update together on out_ce.
// Backpressure: none. The input is strobed by pix_ce, and pixels beyond H_ACTIVE are dropped and flagged on overflow.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   pix_ce, video_valid     native pixel strobe and its active-video qualifier
//   r_sig, g_sig, b_sig     RGB332 input pixel
//   vsync_in                native vsync, captured at each line end
//   out_ce                  one-cycle output pixel strobe, every CLK_PER_PIX/2 clk
//   out_de, out_hsync       output data enable and active-high hsync
//   out_vsync               vsync, updated when a new line starts replaying
//   out_r, out_g, out_b     output pixel (black outside valid data)
//   overflow                sticky flag: a line held more than H_ACTIVE pixels
module scan_doubler #(
  parameter int CLK_PER_PIX = 8,
  parameter int H_ACTIVE    = 256,  // power of two: both banks share one array
  parameter int H_TOTAL     = 384,
  parameter int HS_START    = 272,
  parameter int HS_END      = 304
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  input  logic       video_valid,
  input  logic [2:0] r_sig,
  input  logic [2:0] g_sig,
  input  logic [1:0] b_sig,
  input  logic       vsync_in,
  output logic       out_ce,
  output logic       out_de,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic [2:0] out_r,
  output logic [2:0] out_g,
  output logic [1:0] out_b,
  output logic       overflow
);

  localparam int HALF = CLK_PER_PIX / 2;
  localparam int DW   = (HALF > 2) ? $clog2(HALF) : 1;
  localparam int AW   = $clog2(H_ACTIVE);
  localparam int XW   = $clog2(H_ACTIVE + 1);
  localparam int HW   = $clog2(H_TOTAL);

  // ---------------- write side ----------------
  logic                   wr_bank_q, wr_bank_d;
  logic [XW-1:0]          wr_x_q, wr_x_d;
  logic [1:0][XW-1:0]     wr_len_q, wr_len_d;
  logic                   line_ready_q, line_ready_d;
  logic                   vs_latch_q, vs_latch_d;
  logic                   overflow_q, overflow_d;
  logic                   restart_q;

  logic pix_wr;
  logic line_end;

  assign pix_wr   = pix_ce && video_valid && (wr_x_q < XW'(H_ACTIVE));
  // An invalid strobe only ends a line if that line held at least one pixel.
  assign line_end = pix_ce && !video_valid && (wr_x_q != '0);

  always_comb begin
    wr_x_d       = wr_x_q;
    wr_bank_d    = wr_bank_q;
    wr_len_d     = wr_len_q;
    line_ready_d = line_ready_q;
    vs_latch_d   = vs_latch_q;
    overflow_d   = overflow_q;
    if (pix_ce && video_valid) begin
      if (wr_x_q < XW'(H_ACTIVE)) wr_x_d = wr_x_q + XW'(1);
      else                        overflow_d = 1'b1;
    end
    if (line_end) begin
      wr_len_d[wr_bank_q] = wr_x_q;
      wr_bank_d           = ~wr_bank_q;
      wr_x_d              = '0;
      line_ready_d        = 1'b1;
      vs_latch_d          = vsync_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_x_q       <= '0;
      wr_bank_q    <= 1'b0;
      wr_len_q     <= '0;
      line_ready_q <= 1'b0;
      vs_latch_q   <= 1'b0;
      overflow_q   <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      wr_x_q       <= wr_x_d;
      wr_bank_q    <= wr_bank_d;
      wr_len_q     <= wr_len_d;
      line_ready_q <= line_ready_d;
      vs_latch_q   <= vs_latch_d;
      overflow_q   <= overflow_d;
      restart_q    <= line_end;
    end
  end

  // ---------------- ping-pong line buffers ----------------
  // Bank select is the address MSB. Write and read always target opposite banks.
  logic [7:0] buf_mem [2*H_ACTIVE];
  logic [7:0] rd_dat_q;
  logic       rd_bank_q, rd_bank_d;
  logic [HW-1:0] out_h_q, out_h_d;

  always_ff @(posedge clk) begin
    if (pix_wr) buf_mem[{wr_bank_q, wr_x_q[AW-1:0]}] <= {r_sig, g_sig, b_sig};
    // Read continuously at the current slot. Data is ready one cycle before the tick.
    rd_dat_q <= buf_mem[{rd_bank_q, out_h_q[AW-1:0]}];
  end

  // ---------------- read side ----------------
  logic [DW-1:0] div_q, div_d;
  logic          pass_q, pass_d;
  logic          vsync_q, vsync_d;
  logic          tick;
  logic          wrap;

  assign tick = (div_q == DW'(HALF - 1));
  assign wrap = tick && (out_h_q == HW'(H_TOTAL - 1));

  always_comb begin
    div_d     = tick ? '0 : div_q + DW'(1);
    out_h_d   = out_h_q;
    pass_d    = pass_q | wrap;   // after the second pass, out_h free-runs on the same bank
    rd_bank_d = rd_bank_q;
    vsync_d   = vsync_q;
    if (tick) out_h_d = wrap ? '0 : out_h_q + HW'(1);
    // A restart wins over a coincident wrap. wr_bank has already flipped,
    // so the bank that just completed is the other one.
    if (restart_q) begin
      div_d     = '0;
      out_h_d   = '0;
      pass_d    = 1'b0;
      rd_bank_d = ~wr_bank_q;
      vsync_d   = vs_latch_q;
    end
  end

  logic       de_nxt;
  logic       hs_nxt;
  logic       len_ok;
  logic       out_ce_q, out_de_q, out_hs_q;
  logic [7:0] out_rgb_q;

  assign de_nxt = line_ready_q && (out_h_q < HW'(H_ACTIVE));
  assign hs_nxt = (out_h_q >= HW'(HS_START)) && (out_h_q < HW'(HS_END));
  assign len_ok = out_h_q < HW'(wr_len_q[rd_bank_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      out_h_q   <= '0;
      pass_q    <= 1'b0;
      rd_bank_q <= 1'b0;
      vsync_q   <= 1'b0;
      out_ce_q  <= 1'b0;
      out_de_q  <= 1'b0;
      out_hs_q  <= 1'b0;
      out_rgb_q <= '0;
    end else begin
      div_q     <= div_d;
      out_h_q   <= out_h_d;
      pass_q    <= pass_d;
      rd_bank_q <= rd_bank_d;
      vsync_q   <= vsync_d;
      // The slot in flight at a restart is still emitted, which keeps out_ce regular.
      out_ce_q  <= tick;
      if (tick) begin
        out_de_q  <= de_nxt;
        out_hs_q  <= hs_nxt;
        out_rgb_q <= (de_nxt && len_ok) ? rd_dat_q : 8'h00;
      end
    end
  end

  assign out_ce    = out_ce_q;
  assign out_de    = out_de_q;
  assign out_hsync = out_hs_q;
  assign out_vsync = vsync_q;
  assign out_r     = out_rgb_q[7:5];
  assign out_g     = out_rgb_q[4:2];
  assign out_b     = out_rgb_q[1:0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_scan_doubler.sv
// Testbench for scan_doubler: scoreboard of expected doubled lines checked on every output strobe.
// Latency: n/a.
// Backpressure: n/a.
module tb_scan_doubler;

  localparam int CPP      = 8;
  localparam int H_ACTIVE = 256;
  localparam int H_TOTAL  = 384;
  localparam int HS_START = 272;
  localparam int HS_END   = 304;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_ce;
  logic       video_valid;
  logic [2:0] r_sig;
  logic [2:0] g_sig;
  logic [1:0] b_sig;
  logic       vsync_in;
  logic       out_ce;
  logic       out_de;
  logic       out_hsync;
  logic       out_vsync;
  logic [2:0] out_r;
  logic [2:0] out_g;
  logic [1:0] out_b;
  logic       overflow;

  always #5 clk = ~clk;

  scan_doubler #(
    .CLK_PER_PIX(CPP), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .HS_START(HS_START), .HS_END(HS_END)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .video_valid(video_valid),
    .r_sig(r_sig), .g_sig(g_sig), .b_sig(b_sig), .vsync_in(vsync_in),
    .out_ce(out_ce), .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .overflow(overflow)
  );

  typedef struct packed {
    logic [7:0] rgb;
    logic       vs;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mon_en = 1'b1;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix_val(input int kind, input int x, input logic [7:0] c);
    case (kind)
      0:       return 8'(8'hA0 + x);
      1:       return 8'(x) ^ 8'h5A;
      2:       return 8'(x * 3);
      default: return c;
    endcase
  endfunction

  // One pix_ce strobe followed by CPP-1 idle cycles.
  task automatic drive_pix(input logic v, input logic [7:0] p);
    @(negedge clk);
    pix_ce = 1'b1;
    video_valid = v;
    {r_sig, g_sig, b_sig} = p;
    @(negedge clk);
    pix_ce = 1'b0;
    repeat (CPP - 2) @(negedge clk);
  endtask

  // Each input line takes H_TOTAL strobes: blanking first, then n valid pixels.
  // The line therefore ends on the first strobe of the next line, keeping
  // line ends exactly two output lines apart.
  task automatic drive_line(input int n, input int kind, input logic [7:0] c,
                            input logic vs, input bit push);
    for (int i = 0; i < H_TOTAL - n; i++) drive_pix(1'b0, 8'h00);
    for (int x = 0; x < n; x++) drive_pix(1'b1, pix_val(kind, x, c));
    vsync_in = vs;  // sampled by the next strobe, which ends this line
    if (push) begin
      for (int p = 0; p < 2; p++)
        for (int x = 0; x < H_ACTIVE; x++)
          sb_q.push_back('{rgb: (x < n) ? pix_val(kind, x, c) : 8'h00, vs: vs});
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ce"},    out_ce,    0);
    chk({tag, "_de"},    out_de,    0);
    chk({tag, "_hsync"}, out_hsync, 0);
    chk({tag, "_vsync"}, out_vsync, 0);
    chk({tag, "_rgb"},   {out_r, out_g, out_b}, 0);
    chk({tag, "_ovf"},   overflow,  0);
  endtask

  // Output monitor: the slot index is counted from the first de strobe of each output line.
  exp_t e;
  logic de_prev = 1'b0;
  int   slot = -1;
  int   last_ce = 0;

  always @(negedge clk) begin
    if (mon_en && rst_n && out_ce) begin
      if (out_de) begin
        if (de_prev) begin
          chk("ce_period", cyc - last_ce, CPP / 2);
          slot++;
        end else begin
          slot = 0;
        end
        chk("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rgb", {out_r, out_g, out_b}, e.rgb);
          chk("vsync", out_vsync, e.vs);
        end
      end else begin
        chk("blank_rgb", {out_r, out_g, out_b}, 0);
        if (slot >= 0) slot++;
      end
      if (slot >= 0 && slot < H_TOTAL)
        chk("hsync", out_hsync, (slot >= HS_START && slot < HS_END) ? 1 : 0);
      de_prev = out_de;
      last_ce = cyc;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    pix_ce = 1'b0;
    video_valid = 1'b0;
    {r_sig, g_sig, b_sig} = 8'h00;
    vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Partial line, then a 3-cycle reset in the middle of it.
    for (int x = 0; x < 50; x++) drive_pix(1'b1, 8'(x + 1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    drive_line(256, 0, 8'h00, 1'b0, 1'b1);   // full line
    chk("ovf_after_full", overflow, 0);
    drive_line(100, 1, 8'h00, 1'b0, 1'b1);   // short line
    chk("ovf_after_short", overflow, 0);
    drive_line(300, 2, 8'h00, 1'b0, 1'b1);   // overflowing line
    chk("ovf_set", overflow, 1);
    drive_line(200, 1, 8'h00, 1'b0, 1'b1);   // line after overflow
    drive_line(256, 3, 8'h11, 1'b0, 1'b1);   // ping-pong colours
    drive_line(256, 3, 8'h22, 1'b1, 1'b1);   // vsync_in high at this line's end
    drive_line(256, 3, 8'h33, 1'b0, 1'b1);
    drive_line(10, 3, 8'h44, 1'b0, 1'b0);    // terminator, flushes the 0x33 line
    // End the terminator, then stop monitoring before its replay starts.
    @(negedge clk);
    pix_ce = 1'b1;
    video_valid = 1'b0;
    @(negedge clk);
    pix_ce = 1'b0;
    mon_en = 1'b0;
    chk("sb_drained", sb_q.size(), 0);
    chk("ovf_sticky", overflow, 1);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_doubler.md
Name: scan_doubler

Overview:
- Sits directly downstream of the palette stage. Consumes its registered RGB332 pixel and the video_valid qualifier at the native pixel rate.
- Emits every active line twice at double rate, as a 31 kHz-class VGA-style stream with its own hsync and data-enable.
- One clock domain. Rate conversion uses a clock-enable scheme and a ping-pong pair of line buffers.

Parameters:
- CLK_PER_PIX, 8: clk cycles per input pixel. Must be even and ≥4. An output pixel occurs every CLK_PER_PIX/2 cycles.
- H_ACTIVE, 256: maximum active pixels per line. Also the depth of each line buffer.
- H_TOTAL, 384: output pixel slots per output line (active plus blanking).
- HS_START, 272: first output slot with out_hsync asserted.
- HS_END, 304: first output slot with out_hsync deasserted again.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_ce  in  1  one-cycle input pixel strobe, once every CLK_PER_PIX cycles.
- video_valid  in  1  active-video qualifier from the palette stage.
- r_sig  in  3  red.
- g_sig  in  3  green.
- b_sig  in  2  blue.
- vsync_in  in  1  native vertical sync, sampled at line swap.
- out_ce  out  1  one-cycle output pixel strobe.
- out_de  out  1  output active-video enable.
- out_hsync  out  1  active-high horizontal sync.
- out_vsync  out  1  vertical sync, aligned to output line start.
- out_r  out  3  red.
- out_g  out  3  green.
- out_b  out  2  blue.
- overflow  out  1  sticky: a line exceeded H_ACTIVE pixels.

Behaviour:
- Reset (async assert, sync deassert) forces these values:
  - all outputs 0;
  - wr_x=0, wr_bank=0, wr_len to 0 for both banks;
  - line_ready=0, out_h=0, pass=0;
  - the internal ce divider counter to 0.
  A reset mid-line abandons that line; the next line is written fresh into bank 0.
- Write side:
  - On pix_ce with video_valid=1: if wr_x<H_ACTIVE, store {r,g,b} at bank wr_bank, address wr_x, then increment wr_x. Otherwise drop the pixel and set overflow. overflow clears only on reset.
  - Line end is the first pix_ce with video_valid=0 after at least one valid pixel. At line end:
    - record wr_len[wr_bank]=wr_x;
    - flip wr_bank and clear wr_x;
    - set line_ready=1;
    - capture vsync_in into vs_latch;
    - issue the restart pulse to the read side.
  - A pix_ce with video_valid=0 and wr_x=0 is not a line end (no pulse).
- Read side:
  - A divider generates out_ce every CLK_PER_PIX/2 cycles. out_h counts 0..H_TOTAL-1 on out_ce and wraps to 0.
  - On wrap, pass toggles 0→1. When pass=1 wraps, out_h stays free-running and rd_bank is unchanged (line is repeated once more only if a restart comes).
  - On the restart pulse, the divider, out_h and pass reset to 0 on the next cycle. rd_bank becomes the just-completed bank and out_vsync←vs_latch.
  - Restart has priority over a coincident wrap.
- Output, registered, updated on out_ce:
  - out_de=1 when line_ready=1 and out_h<H_ACTIVE.
  - out_hsync=1 when HS_START≤out_h<HS_END, independent of line_ready.
  - RGB equals buffer[rd_bank][out_h] when out_de=1 and out_h<wr_len[rd_bank]; otherwise 0 (short-line padding and blanking both output black).
  - Buffer read latency is 1 cycle. The read address is presented one cycle before out_ce so the registered pixel, de and hsync stay aligned (same out_ce edge).
- Simultaneous write and read on the same bank cannot occur, because write and read always use opposite banks after a swap.
- Before the first line_ready, syncs run and the output is black with out_de=0.

Test Plan:
- Reset mid-line: toggle rst_n low for 3 cycles during active write. Required: all outputs 0 immediately. The next line lands in bank 0, and overflow stays 0.
- Single full line: 256 valid pixels with value 0xA0+x mod 256, then invalid. Required: 2 consecutive output lines, each with 256 out_de strobes carrying the identical sequence; out_ce period 4 clk; hsync high exactly for slots 272–303.
- Short line: 100 valid pixels. Required: out_de high for 256 slots per output line; slots 100–255 output RGB=0; both passes identical.
- Overflow: 300 valid pixels. Required: the first 256 are output, overflow=1 sticky through subsequent lines, and the next line is written correctly.
- Ping-pong: 3 lines with constant colours 0x11, 0x22, 0x33. Required: output sequence 0x11,0x11,0x22,0x22,0x33,0x33 with no mixed-colour line.
- vsync: assert vsync_in before the line-2 end. Required: out_vsync=1 from the first output slot of line 2's doubled output, and returns to 0 after the line where vsync_in was sampled low.
